gradient_collector: RTL

- Sink end of the loss stage's two-column gradient interface.
- Accepts the per-column gradient/valid streams, which arrive skewed because column 2 trails column 1 in the systolic flow.
- Buffers each column in a small FIFO, re-aligns the columns into one row word, and hands rows downstream with a valid/ready handshake.
- Counts rows for one batch and signals completion to the controller.

---
 rtl/gradient_collector.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/gradient_collector.sv
// ---------------------------------------------------------------------------
// gradient_collector
//   Sink end of the loss stage's two-column gradient interface. The two
//   column streams arrive skewed (column 2 trails column 1), so each column
//   is buffered in its own small FIFO. When both columns have an element,
//   the heads are popped together into a row output register, which is then
//   offered downstream. Rows are counted against the batch size that was
//   latched on start_in, and completion is signalled with a one-cycle
//   done_out pulse.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   start_in       one-cycle pulse in IDLE: begin a batch
//   num_rows_in    rows in the batch, sampled on start_in
//   gradient_k_in  column k gradient, signed Q8.8, passed through bit-exact
//   valid_k_in     column k element valid (only accepted in COLLECT)
//   row_ready_in   downstream accepts the presented row
//   row_valid_out  row word valid
//   row_1_out      column 1 element of the row
//   row_2_out      column 2 element of the row
//   row_index_out  0-based index of the presented row (row counter)
//   busy_out       high while collecting
//   done_out       one-cycle pulse after the last row handshake
//   overflow_out   sticky: an element was dropped on a full FIFO
//   state_out      current FSM state (0 IDLE, 1 COLLECT, 2 DONE)
//
// Handshake: a row transfers on every rising edge where
// row_valid_out & row_ready_in are both high. Once row_valid_out is raised,
// it and the row data stay unchanged until that transfer happens.
// ---------------------------------------------------------------------------
module gradient_collector #(
   parameter int DEPTH = 4,
   parameter int ROW_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_in,
   input  logic [ROW_W-1:0] num_rows_in,
   input  logic [15:0]      gradient_1_in,
   input  logic [15:0]      gradient_2_in,
   input  logic             valid_1_in,
   input  logic             valid_2_in,
   input  logic             row_ready_in,
   output logic             row_valid_out,
   output logic [15:0]      row_1_out,
   output logic [15:0]      row_2_out,
   output logic [ROW_W-1:0] row_index_out,
   output logic             busy_out,
   output logic             done_out,
   output logic             overflow_out,
   output logic [1:0]       state_out
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           r_state;
   logic [ROW_W-1:0] r_num_rows;
   logic [ROW_W-1:0] r_row_cnt;
   logic             r_row_valid;
   logic [15:0]      r_row_1;
   logic [15:0]      r_row_2;
   logic             r_busy;
   logic             r_done;
   logic             r_overflow;

   // Column FIFOs: index 0 is column 1, index 1 is column 2.
   logic [15:0]      r_mem [2][DEPTH];
   logic [PW-1:0]    r_wp  [2];
   logic [PW-1:0]    r_rp  [2];
   logic [CW-1:0]    r_cnt [2];

   logic [15:0]      w_grad [2];
   logic [15:0]      w_head [2];
   logic [1:0]       w_push;
   logic [1:0]       w_avail;
   logic [1:0]       w_full;
   logic [1:0]       w_pop;
   logic [1:0]       w_wr;
   logic [1:0]       w_drop;
   logic             w_hs;
   logic             w_hs_last;
   logic             w_load;

   always_comb begin
      w_grad[0] = gradient_1_in;
      w_grad[1] = gradient_2_in;
      w_push[0] = valid_1_in && (r_state == S_COLLECT);
      w_push[1] = valid_2_in && (r_state == S_COLLECT);

      w_hs      = r_row_valid && row_ready_in;
      w_hs_last = w_hs && (r_row_cnt == r_num_rows - ROW_W'(1));

      // An empty FIFO with a push this cycle counts as available: the
      // incoming element bypasses the storage straight into the row
      // register, so a row appears the cycle after its later element.
      for (int k = 0; k < 2; k++) begin
         w_full[k]  = (r_cnt[k] == CW'(DEPTH));
         w_avail[k] = (r_cnt[k] != '0) || w_push[k];
         w_head[k]  = (r_cnt[k] != '0) ? r_mem[k][r_rp[k]] : w_grad[k];
      end

      // No load on the final handshake: the batch ends there.
      w_load = (r_state == S_COLLECT) && !w_hs_last && (&w_avail) &&
               (!r_row_valid || row_ready_in);

      for (int k = 0; k < 2; k++) begin
         w_pop[k]  = w_load && (r_cnt[k] != '0);
         // A bypassed push is consumed by the row register, not stored.
         w_wr[k]   = w_push[k] && !(w_load && (r_cnt[k] == '0)) &&
                     (!w_full[k] || w_pop[k]);
         w_drop[k] = w_push[k] && w_full[k] && !w_pop[k];
      end
   end

   // FIFO storage carries no reset; only pointers and counts do.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (w_wr[k]) r_mem[k][r_wp[k]] <= w_grad[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_num_rows  <= '0;
         r_row_cnt   <= '0;
         r_row_valid <= 1'b0;
         r_row_1     <= '0;
         r_row_2     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overflow  <= 1'b0;
         for (int k = 0; k < 2; k++) begin
            r_wp[k]  <= '0;
            r_rp[k]  <= '0;
            r_cnt[k] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_in) begin
                  r_num_rows  <= num_rows_in;
                  r_row_cnt   <= '0;
                  r_overflow  <= 1'b0;
                  r_row_valid <= 1'b0;
                  for (int k = 0; k < 2; k++) begin
                     r_wp[k]  <= '0;
                     r_rp[k]  <= '0;
                     r_cnt[k] <= '0;
                  end
                  if (num_rows_in == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_COLLECT;
                     r_busy  <= 1'b1;
                  end
               end
            end

            S_COLLECT: begin
               if (w_hs) r_row_cnt <= r_row_cnt + ROW_W'(1);
               if (w_hs_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end

               if (w_load) begin
                  r_row_valid <= 1'b1;
                  r_row_1     <= w_head[0];
                  r_row_2     <= w_head[1];
               end else if (w_hs) begin
                  r_row_valid <= 1'b0;
               end

               if (|w_drop) r_overflow <= 1'b1;

               for (int k = 0; k < 2; k++) begin
                  if (w_wr[k])  r_wp[k] <= r_wp[k] + PW'(1);
                  if (w_pop[k]) r_rp[k] <= r_rp[k] + PW'(1);
                  case ({w_wr[k], w_pop[k]})
                     2'b10:   r_cnt[k] <= r_cnt[k] + CW'(1);
                     2'b01:   r_cnt[k] <= r_cnt[k] - CW'(1);
                     default: ;
                  endcase
               end
            end

            S_DONE: begin
               // Leftover elements of the batch are discarded silently.
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               for (int k = 0; k < 2; k++) begin
                  r_wp[k]  <= '0;
                  r_rp[k]  <= '0;
                  r_cnt[k] <= '0;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign row_valid_out = r_row_valid;
   assign row_1_out     = r_row_1;
   assign row_2_out     = r_row_2;
   assign row_index_out = r_row_cnt;
   assign busy_out      = r_busy;
   assign done_out      = r_done;
   assign overflow_out  = r_overflow;
   assign state_out     = r_state;

endmodule
